// File: rtl/user_position_ctl_pkg.sv
// Shared types and constants for the user-position slice.
// Screen geometry is shared with the VGA timing generator.
package user_position_ctl_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int POS_W    = 12;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    REQ,
    WAIT,
    COMMIT
  } state_t;

  // Saturate a signed candidate to 0..hi
  function automatic logic [POS_W-1:0] clamp_pos(
    input logic signed [POS_W:0] v,
    input logic [POS_W-1:0]      hi
  );
    if (v[POS_W])
      return '0;
    if (v > $signed({1'b0, hi}))
      return hi;
    return v[POS_W-1:0];
  endfunction

endpackage

// File: rtl/user_position_ctl_frame_tick_gen.sv
// Frame tick from the vsync rising edge, divided down
// to one step_due every FRAMES_PER_STEP frames.
module frame_tick_gen #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick,
  output logic step_due
);

  localparam int CW =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

  logic          vsync_d;
  logic [CW-1:0] cnt;

  assign tick     = vsync_in & ~vsync_d;
  assign step_due = tick & (cnt == LAST);

  // Edge-detect register and wrapping frame counter
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d <= 1'b0;
      cnt     <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (tick)
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/user_position_ctl.sv
// Sprite position producer: steps on key input every few frames,
// committing only moves the maze map confirms as free.
module user_position_ctl
  import user_position_ctl_pkg::*;
#(
  parameter int X_INIT          = 350,
  parameter int Y_INIT          = 250,
  parameter int STEP            = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int SPRITE_W        = 100,
  parameter int SPRITE_H        = 100,
  parameter int ACK_TIMEOUT     = 15
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        map_ack,
  input  logic        map_blocked,
  output logic        map_req,
  output logic [11:0] map_x,
  output logic [11:0] map_y,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        moving
);

  localparam logic [POS_W-1:0] X_MAX =
    POS_W'(H_ACTIVE - SPRITE_W);
  localparam logic [POS_W-1:0] Y_MAX =
    POS_W'(V_ACTIVE - SPRITE_H);
  localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);
  localparam logic signed [POS_W:0] STEP_S =
    (POS_W+1)'(STEP);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  logic tick;
  logic step_due;

  state_t state;

  logic signed [1:0] kdx;
  logic signed [1:0] kdy;
  logic signed [1:0] dx;
  logic signed [1:0] dy;

  logic signed [POS_W:0] dx_w;
  logic signed [POS_W:0] dy_w;
  logic signed [POS_W:0] sum_x;
  logic signed [POS_W:0] sum_y;
  logic [POS_W-1:0]      cand_x;
  logic [POS_W-1:0]      cand_y;
  logic [TW-1:0]         tcnt;

  frame_tick_gen #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_tick (
    .pclk    (pclk),
    .rst     (rst),
    .vsync_in(vsync_in),
    .tick    (tick),
    .step_due(step_due)
  );

  assign kdx = $signed({1'b0, key_right})
             - $signed({1'b0, key_left});
  assign kdy = $signed({1'b0, key_down})
             - $signed({1'b0, key_up});

  assign dx_w   = (POS_W+1)'(dx);
  assign dy_w   = (POS_W+1)'(dy);
  assign sum_x  = $signed({1'b0, x_pos}) + dx_w * STEP_S;
  assign sum_y  = $signed({1'b0, y_pos}) + dy_w * STEP_S;
  assign cand_x = clamp_pos(sum_x, X_MAX);
  assign cand_y = clamp_pos(sum_y, Y_MAX);

  // Step sequencer: latch keys, build candidate, query map, commit
  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= IDLE;
      x_pos   <= X_RST;
      y_pos   <= Y_RST;
      map_x   <= X_RST;
      map_y   <= Y_RST;
      map_req <= 1'b0;
      moving  <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      tcnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tick & step_due) begin
            dx <= kdx;
            dy <= kdy;
            if (kdx != 2'sd0 || kdy != 2'sd0) begin
              state  <= CALC;
              moving <= 1'b1;
            end
          end
        end
        CALC: begin
          map_x <= cand_x;
          map_y <= cand_y;
          if (cand_x == x_pos && cand_y == y_pos) begin
            state  <= IDLE;
            moving <= 1'b0;
          end else begin
            state   <= REQ;
            map_req <= 1'b1;
          end
        end
        REQ: begin
          map_req <= 1'b0;
          tcnt    <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (map_ack) begin
            if (map_blocked) begin
              state  <= IDLE;
              moving <= 1'b0;
            end else begin
              state <= COMMIT;
            end
          end else if (tcnt == TO_LAST) begin
            state  <= IDLE;
            moving <= 1'b0;
          end
        end
        COMMIT: begin
          x_pos  <= map_x;
          y_pos  <= map_y;
          moving <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          map_req <= 1'b0;
          moving  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_position_ctl.sv
// Bench for user_position_ctl: timeline-based reference model,
// map responder with scheduled acks, directed and random phases.
module tb_user_position_ctl;

  localparam int X0   = 350;
  localparam int Y0   = 250;
  localparam int STP  = 4;
  localparam int FPS  = 2;
  localparam int XMAX = 700;
  localparam int YMAX = 500;
  localparam int TO   = 15;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        map_ack = 1'b0;
  logic        map_blocked = 1'b0;
  logic        map_req;
  logic [11:0] map_x;
  logic [11:0] map_y;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        moving;

  user_position_ctl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .key_up     (key_up),
    .key_down   (key_down),
    .key_left   (key_left),
    .key_right  (key_right),
    .map_ack    (map_ack),
    .map_blocked(map_blocked),
    .map_req    (map_req),
    .map_x      (map_x),
    .map_y      (map_y),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .moving     (moving)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mx = X0, my = Y0;
  int emx = X0, emy = Y0;
  int cx = X0, cy = Y0;
  int vs_d = 0, fcnt = 0;
  int idle_from = 0;
  int req_cyc = -1, map_cyc = -1, commit_at = -1;
  int ack_cyc = -1, ack_blk = 0;
  int forced_delay = -1, forced_blk = -1;
  int stray_en = 0;
  int req_cnt = 0, last_rx = -1, last_ry = -1;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    int n, tk, due, ddx, ddy, d, blk;
    @(negedge pclk);
    n = cyc + 1;
    map_ack = 1'b0;
    map_blocked = 1'($urandom_range(0, 1));
    if (ack_cyc == n) begin
      map_ack = 1'b1;
      map_blocked = 1'(ack_blk);
    end else if (stray_en != 0 && n - 1 >= idle_from
                 && $urandom_range(0, 9) == 0) begin
      map_ack = 1'b1;
    end
    if (rst) begin
      mx = X0; my = Y0; emx = X0; emy = Y0;
      vs_d = 0; fcnt = 0;
      idle_from = n;
      req_cyc = -1; map_cyc = -1; commit_at = -1; ack_cyc = -1;
    end else begin
      tk  = (vsync_in && vs_d == 0) ? 1 : 0;
      due = (tk == 1 && fcnt == FPS - 1) ? 1 : 0;
      if (tk == 1) fcnt = (fcnt + 1) % FPS;
      vs_d = int'(vsync_in);
      if (commit_at == n) begin mx = cx; my = cy; end
      if (map_cyc == n) begin emx = cx; emy = cy; end
      if (due == 1 && n - 1 >= idle_from) begin
        ddx = int'(key_right) - int'(key_left);
        ddy = int'(key_down) - int'(key_up);
        if (ddx != 0 || ddy != 0) begin
          cx = clampi(mx + ddx * STP, XMAX);
          cy = clampi(my + ddy * STP, YMAX);
          map_cyc = n + 1;
          if (cx == mx && cy == my) begin
            idle_from = n + 1;
            req_cyc = -1;
          end else begin
            req_cyc = n + 1;
            d = (forced_delay >= 0) ? forced_delay
                                    : $urandom_range(0, 16);
            blk = (forced_blk >= 0) ? forced_blk
                                    : $urandom_range(0, 1);
            ack_cyc = n + 3 + d;
            ack_blk = blk;
            if (d <= TO - 1) begin
              if (blk != 0) idle_from = ack_cyc;
              else begin
                idle_from = ack_cyc + 1;
                commit_at = ack_cyc + 1;
              end
            end else begin
              idle_from = n + 2 + TO;
            end
          end
        end
      end
    end
    @(posedge pclk);
    cyc = n;
    #1;
    if (map_req) begin
      req_cnt++;
      last_rx = int'(map_x);
      last_ry = int'(map_y);
    end
    chk("x_pos", int'(x_pos), mx);
    chk("y_pos", int'(y_pos), my);
    chk("map_x", int'(map_x), emx);
    chk("map_y", int'(map_y), emy);
    chk("map_req", int'(map_req), (n == req_cyc) ? 1 : 0);
    chk("moving", int'(moving), (n < idle_from) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync_in = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    req_cnt = 0;
  endtask

  task automatic frame(int hi, int lo);
    vsync_in = 1'b1;
    repeat (hi) cycle();
    vsync_in = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic keys(logic u, logic dn, logic l, logic r);
    key_up = u; key_down = dn; key_left = l; key_right = r;
  endtask

  task automatic step2();
    frame(1, 30);
    frame(1, 30);
  endtask

  initial begin
    do_reset();
    repeat (3) cycle();
    chk("lit_rst_x", int'(x_pos), 350);
    chk("lit_rst_y", int'(y_pos), 250);
    chk("lit_rst_req", int'(map_req), 0);
    chk("lit_rst_mov", int'(moving), 0);

    keys(0, 0, 0, 1);
    forced_delay = 0; forced_blk = 0;
    step2();
    chk("lit_req_x", last_rx, 354);
    chk("lit_req_y", last_ry, 250);
    chk("lit_commit_x", int'(x_pos), 354);
    chk("lit_commit_y", int'(y_pos), 250);
    chk("lit_req_cnt", req_cnt, 1);

    do_reset();
    forced_blk = 1;
    step2();
    chk("lit_blocked_x", int'(x_pos), 350);
    chk("lit_blocked_req", req_cnt, 1);

    do_reset();
    keys(0, 0, 1, 1);
    step2();
    step2();
    chk("lit_cancel_req", req_cnt, 0);

    do_reset();
    keys(1, 0, 0, 1);
    forced_blk = 0;
    step2();
    chk("lit_diag_mx", last_rx, 354);
    chk("lit_diag_my", last_ry, 246);

    do_reset();
    repeat (90) step2();
    chk("lit_edge_x", int'(x_pos), 700);
    chk("lit_edge_y", int'(y_pos), 0);
    req_cnt = 0;
    step2();
    chk("lit_edge_noreq", req_cnt, 0);

    do_reset();
    keys(0, 0, 0, 1);
    forced_delay = 16;
    step2();
    chk("lit_to_x", int'(x_pos), 350);
    chk("lit_to_req", req_cnt, 1);
    forced_delay = 0;
    step2();
    chk("lit_retry_req", req_cnt, 2);
    chk("lit_retry_x", int'(x_pos), 354);

    do_reset();
    forced_delay = 16;
    frame(1, 30);
    vsync_in = 1'b1;
    cycle();
    vsync_in = 1'b0;
    repeat (5) cycle();
    chk("lit_wait_mov", int'(moving), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("lit_rstw_req", int'(map_req), 0);
    ack_cyc = cyc + 2;
    ack_blk = 0;
    repeat (20) cycle();
    chk("lit_rstw_x", int'(x_pos), 350);
    chk("lit_rstw_y", int'(y_pos), 250);

    forced_delay = -1;
    forced_blk = -1;
    stray_en = 1;
    for (int f = 0; f < 120; f++) begin
      keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 24) == 0) do_reset();
      frame($urandom_range(1, 3), $urandom_range(4, 40));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
